sync_fifo: RTL and testbench



---
 rtl/sync_fifo.sv | 90 +++++++++
 tb/tb_sync_fifo.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO: register-array circular buffer with binary pointers,
// an occupancy counter, count-decoded status flags and a registered read port.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enb,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  half,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   HALF_C  = (AW+1)'(DEPTH / 2);
  localparam logic [AW:0]   AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_C    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW:0]           count_r;
  logic [AW:0]           count_nxt_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;

  // Flags are pure decodes of the registered count, so they track it with no lag.
  assign full         = (count_r == DEPTH_C);
  assign empty        = (count_r == {(AW+1){1'b0}});
  assign almost_full  = (count_r >= AF_C);
  assign almost_empty = (count_r <= AE_C);
  assign half         = (count_r >= HALF_C);

  assign wr_ok_s = wr_enb & ~full;
  assign rd_ok_s = rd_enb & ~empty;

  // Occupancy update: a simultaneous accepted read and write cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (rst && wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, counter, read data register and error pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      rd_data  <= {DATA_WIDTH{1'b0}};
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        rd_data  <= mem_r[rd_ptr_r];
      end
      count_r <= count_nxt_s;
      wr_err  <= wr_enb & full;
      rd_err  <= rd_enb & empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a table of directed vectors, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_enb;
  logic [DW-1:0] wr_data;
  logic          rd_enb;
  logic [DW-1:0] rd_data;
  logic          full, empty, almost_full, almost_empty, half, wr_err, rd_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_rd_data;
  bit            m_wr_err, m_rd_err;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_data(wr_data), .rd_enb(rd_enb),
    .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .half(half), .wr_err(wr_err), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rst_n;
    bit            wr;
    bit            rd;
    logic [DW-1:0] din;
    bit            e_full, e_empty, e_af, e_ae, e_half, e_werr, e_rerr;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance past the edge, update the model.
  task automatic drive(input bit r, input bit w, input bit rd, input logic [DW-1:0] d);
    bit was_full, was_empty;
    rst = r; wr_enb = w; rd_enb = rd; wr_data = d;
    @(posedge clk);
    #1;
    if (!r) begin
      q.delete();
      m_rd_data = '0;
      m_wr_err  = 1'b0;
      m_rd_err  = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (rd && !was_empty) m_rd_data = q.pop_front();
      if (w && !was_full) q.push_back(d);
      m_wr_err = w && was_full;
      m_rd_err = rd && was_empty;
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, ".full"},   full,         32'(n == DEPTH));
    chk({tag, ".empty"},  empty,        32'(n == 0));
    chk({tag, ".af"},     almost_full,  32'(n >= AF));
    chk({tag, ".ae"},     almost_empty, 32'(n <= AE));
    chk({tag, ".half"},   half,         32'(n >= DEPTH / 2));
    chk({tag, ".wr_err"}, wr_err,       32'(m_wr_err));
    chk({tag, ".rd_err"}, rd_err,       32'(m_rd_err));
    chk({tag, ".rd_data"}, rd_data,     32'(m_rd_data));
  endtask

  function automatic vec_t mk(bit r, bit w, bit rd, logic [DW-1:0] d, int cnt,
                              bit werr, bit rerr, logic [DW-1:0] erd);
    vec_t v;
    v.rst_n = r; v.wr = w; v.rd = rd; v.din = d;
    v.e_full = (cnt == 16); v.e_empty = (cnt == 0); v.e_af = (cnt >= 14);
    v.e_ae = (cnt <= 2); v.e_half = (cnt >= 8);
    v.e_werr = werr; v.e_rerr = rerr; v.e_rd = erd;
    return v;
  endfunction

  initial begin
    rst = 1'b0; wr_enb = 1'b0; rd_enb = 1'b0; wr_data = '0;
    m_rd_data = '0; m_wr_err = 1'b0; m_rd_err = 1'b0;

    // Directed table: reset with writes pending, fill, overflow, drain, underflow.
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h33, 0, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h34, 0, 1'b0, 1'b0, 8'h00));
    for (int k = 1; k <= 16; k++)
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 8'(k), k, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 8'hFF, 16, 1'b1, 1'b0, 8'h00));
    for (int j = 1; j <= 16; j++)
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, 8'h00, 16 - j, 1'b0, 1'b0, 8'(j)));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 8'h10));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h10));

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("tbl%0d.full", i),    full,         32'(tbl[i].e_full));
      chk($sformatf("tbl%0d.empty", i),   empty,        32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d.af", i),      almost_full,  32'(tbl[i].e_af));
      chk($sformatf("tbl%0d.ae", i),      almost_empty, 32'(tbl[i].e_ae));
      chk($sformatf("tbl%0d.half", i),    half,         32'(tbl[i].e_half));
      chk($sformatf("tbl%0d.wr_err", i),  wr_err,       32'(tbl[i].e_werr));
      chk($sformatf("tbl%0d.rd_err", i),  rd_err,       32'(tbl[i].e_rerr));
      chk($sformatf("tbl%0d.rd_data", i), rd_data,      32'(tbl[i].e_rd));
    end

    // Pointer wrap: 10 in/out, then 12 values 0xA0..0xAB across the wrap.
    for (int i = 0; i < 10; i++) begin drive(1'b1, 1'b1, 1'b0, 8'(i)); check_model("wrap_w"); end
    for (int i = 0; i < 10; i++) begin drive(1'b1, 1'b0, 1'b1, 8'h00); check_model("wrap_r"); end
    for (int i = 0; i < 12; i++) begin drive(1'b1, 1'b1, 1'b0, 8'hA0 + 8'(i)); check_model("wrap_w2"); end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      chk("wrap_order", rd_data, 32'(8'hA0 + 8'(i)));
    end
    chk("wrap_empty", empty, 32'd1);

    // Simultaneous read+write at count 5: count holds, oldest entry comes out.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 8'h50 + 8'(i));
    drive(1'b1, 1'b1, 1'b1, 8'h5F);
    chk("both5_rd", rd_data, 32'h50);
    check_model("both5");
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 1'b1, 8'h00); check_model("both5_drain"); end

    // Simultaneous at full: read wins, write dropped with wr_err.
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b0, 8'hC0 + 8'(i));
    drive(1'b1, 1'b1, 1'b1, 8'hEE);
    chk("bothfull_full", full, 32'd0);
    chk("bothfull_werr", wr_err, 32'd1);
    chk("bothfull_rd", rd_data, 32'hC0);
    check_model("bothfull");
    for (int i = 0; i < 15; i++) begin drive(1'b1, 1'b0, 1'b1, 8'h00); check_model("bothfull_drain"); end

    // Simultaneous at empty: write wins, read ignored with rd_err, no bypass.
    drive(1'b1, 1'b1, 1'b1, 8'h77);
    chk("bothempty_rerr", rd_err, 32'd1);
    chk("bothempty_empty", empty, 32'd0);
    chk("bothempty_nobypass", rd_data, 32'hCF);
    check_model("bothempty");
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    chk("bothempty_rd", rd_data, 32'h77);

    // Reset mid-operation at count 9, then no stale data afterwards.
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, 1'b0, 8'h90 + 8'(i));
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("midrst_empty", empty, 32'd1);
    check_model("midrst");
    drive(1'b1, 1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    chk("midrst_rd", rd_data, 32'h55);
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    chk("midrst_rerr", rd_err, 32'd1);
    check_model("midrst_post");

    // Randomized traffic with drifting write/read bias and occasional reset.
    for (int ph = 0; ph < 12; ph++) begin
      int wb, rb;
      wb = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 50;
      rb = 100 - wb;
      for (int c = 0; c < 150; c++) begin
        drive(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 99) < wb),
              ($urandom_range(0, 99) < rb),
              8'($urandom));
        check_model("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
